wb_arbiter: RTL and testbench

Write-back arbiter and sequencer for the register file's single write port (write enable, write address, write data). Two producers share it: the ALU result path and the load/store unit, each through a valid/ready handshake into a one-entry holding slot. The block drains at most one write per cycle, keeps same-register writes in program order, and drops writes to x0. It also reports combinational pending-write hazards so decode can stall reads of registers whose write has not yet committed.

---
 rtl/rv_pkg.sv | 26 ++
 rtl/wb_slot.sv | 31 +++
 rtl/wb_arbiter.sv | 131 +++++++++++++
 tb/tb_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared register-file write-back types: widths, entry struct, producer enum,
// and the pending-write hazard match helper.
package rv_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ADDRESS_WIDTH = 5;

  typedef logic [ADDRESS_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t             rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LSU = 1'b1
  } wb_src_e;

  // x0 is never written, so it can never be a pending hazard.
  function automatic logic pending_hit(input logic full, input reg_addr_t rd,
                                       input reg_addr_t chk);
    return full && (chk != '0) && (rd == chk);
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding register for a write-back producer. Accepts a push when
// empty or when popped in the same cycle; pushes to x0 are swallowed.
module wb_slot
  import rv_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t push_entry,
  output logic      full,
  output wb_entry_t entry,
  output logic      ready
);

  // Handshake: a transfer happens on a rising edge where push && ready.
  assign ready = !full || pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full  <= 1'b0;
      entry <= '0;
    end else if (push && ready && (push_entry.rd != '0)) begin
      full  <= 1'b1;
      entry <= push_entry;
    end else if (pop) begin
      full  <= 1'b0;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter for the register file's single write port (ALU vs LSU).
// Build option WB_RR_EN: round-robin between producers instead of fixed ALU
// priority with an LSU starvation counter.
module wb_arbiter #(
  parameter int DATA_WIDTH    = rv_pkg::DATA_WIDTH,
  parameter int ADDRESS_WIDTH = rv_pkg::ADDRESS_WIDTH,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [ADDRESS_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [ADDRESS_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_data,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  input  logic [ADDRESS_WIDTH-1:0] chk_a1,
  input  logic [ADDRESS_WIDTH-1:0] chk_a2,
  output logic                     hazard1,
  output logic                     hazard2,
  output logic                     idle
);

  rv_pkg::wb_entry_t alu_push, lsu_push, alu_entry, lsu_entry;
  rv_pkg::wb_src_e   grant;
  logic alu_full, lsu_full, alu_pop, lsu_pop, alu_cap, lsu_cap;
  logic alu_older, contended, same_rd;

  assign alu_push = '{rd: alu_rd, data: alu_data};
  assign lsu_push = '{rd: lsu_rd, data: lsu_data};

  wb_slot u_alu_slot (
    .clk(clk), .rst(rst), .push(alu_valid), .pop(alu_pop),
    .push_entry(alu_push), .full(alu_full), .entry(alu_entry), .ready(alu_ready)
  );

  wb_slot u_lsu_slot (
    .clk(clk), .rst(rst), .push(lsu_valid), .pop(lsu_pop),
    .push_entry(lsu_push), .full(lsu_full), .entry(lsu_entry), .ready(lsu_ready)
  );

  assign contended = alu_full && lsu_full;
  assign same_rd   = (alu_entry.rd == lsu_entry.rd);
  assign alu_cap   = alu_valid && alu_ready && (alu_rd != '0);
  assign lsu_cap   = lsu_valid && lsu_ready && (lsu_rd != '0);

`ifdef WB_RR_EN
  rv_pkg::wb_src_e rr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= rv_pkg::WB_ALU;
    end else if (contended && !same_rd) begin
      rr_ptr <= (grant == rv_pkg::WB_ALU) ? rv_pkg::WB_LSU : rv_pkg::WB_ALU;
    end
  end
`else
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (lsu_pop) begin
      starve_cnt <= '0;
    end else if (contended && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  // Equal-rd ordering beats every fairness rule so same-register writes commit in program order.
  always_comb begin
    grant = rv_pkg::WB_ALU;
    if (lsu_full && !alu_full) begin
      grant = rv_pkg::WB_LSU;
    end else if (contended) begin
      if (same_rd) begin
        grant = alu_older ? rv_pkg::WB_ALU : rv_pkg::WB_LSU;
      end else begin
`ifdef WB_RR_EN
        grant = rr_ptr;
`else
        grant = (starve_cnt == STARVE_MAX) ? rv_pkg::WB_LSU : rv_pkg::WB_ALU;
`endif
      end
    end
  end

  assign alu_pop = alu_full && (grant == rv_pkg::WB_ALU);
  assign lsu_pop = lsu_full && (grant == rv_pkg::WB_LSU);

  // Simultaneous capture counts the ALU entry as older.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_older <= 1'b0;
    end else if (alu_cap) begin
      alu_older <= lsu_cap;
    end else if (lsu_cap) begin
      alu_older <= 1'b1;
    end
  end

  always_comb begin
    WE3 = 1'b0;
    AD3 = '0;
    WD3 = '0;
    if (alu_pop) begin
      WE3 = 1'b1;
      AD3 = alu_entry.rd;
      WD3 = alu_entry.data;
    end else if (lsu_pop) begin
      WE3 = 1'b1;
      AD3 = lsu_entry.rd;
      WD3 = lsu_entry.data;
    end
  end

  assign hazard1 = rv_pkg::pending_hit(alu_full, alu_entry.rd, chk_a1) ||
                   rv_pkg::pending_hit(lsu_full, lsu_entry.rd, chk_a1);
  assign hazard2 = rv_pkg::pending_hit(alu_full, alu_entry.rd, chk_a2) ||
                   rv_pkg::pending_hit(lsu_full, lsu_entry.rd, chk_a2);
  assign idle    = !alu_full && !lsu_full;

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized + directed bench for wb_arbiter with a queue-based scoreboard.
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alu_valid, lsu_valid;
  logic          alu_ready, lsu_ready;
  logic [AW-1:0] alu_rd, lsu_rd, chk_a1, chk_a2, AD3;
  logic [DW-1:0] alu_data, lsu_data, WD3;
  logic          WE3, hazard1, hazard2, idle;

  int checks = 0;
  int failures = 0;

  wb_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .WE3(WE3), .AD3(AD3), .WD3(WD3),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .hazard1(hazard1), .hazard2(hazard2), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Slot 0 = ALU, slot 1 = LSU; age is a global capture sequence number.
  bit          m_full[2];
  logic [4:0]  m_rd[2];
  logic [31:0] m_data[2];
  int unsigned m_seq[2];
  int unsigned seq_ctr;
  int          losses;
  bit          ptr_lsu;

  typedef struct packed {
    logic        we;
    logic [4:0]  ad;
    logic [31:0] wd;
    logic        ar, lr, idl, af;
    logic [4:0]  arr;
    logic        lf;
    logic [4:0]  lrr;
  } exp_t;

  exp_t exp_q[$];
  logic [31:0] rf[32];

  function automatic int winner();
    if (!m_full[0] && !m_full[1]) return -1;
    if (!m_full[1]) return 0;
    if (!m_full[0]) return 1;
    if (m_rd[0] == m_rd[1]) return (m_seq[0] < m_seq[1]) ? 0 : 1;
`ifdef WB_RR_EN
    return ptr_lsu ? 1 : 0;
`else
    return (losses >= LIMIT) ? 1 : 0;
`endif
  endfunction

  function automatic exp_t make_exp();
    exp_t e;
    int w;
    w = winner();
    e = '0;
    e.we  = (w >= 0);
    e.ad  = (w >= 0) ? m_rd[w] : 5'd0;
    e.wd  = (w >= 0) ? m_data[w] : 32'd0;
    e.ar  = !m_full[0] || (w == 0);
    e.lr  = !m_full[1] || (w == 1);
    e.idl = !m_full[0] && !m_full[1];
    e.af  = m_full[0];
    e.arr = m_rd[0];
    e.lf  = m_full[1];
    e.lrr = m_rd[1];
    return e;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_full[0] = 0; m_full[1] = 0;
      losses = 0; ptr_lsu = 0; seq_ctr = 0;
      exp_q.delete();
      exp_q.push_back(make_exp());
    end else begin
      int  w;
      bit  ra, rl, both;
      w    = winner();
      ra   = !m_full[0] || (w == 0);
      rl   = !m_full[1] || (w == 1);
      both = m_full[0] && m_full[1];
      if (w == 1) losses = 0;
      else if (both && losses < LIMIT) losses++;
      if (both && (m_rd[0] != m_rd[1])) ptr_lsu = (w == 0);
      if (w >= 0) m_full[w] = 0;
      if (alu_valid && ra && alu_rd != 0) begin
        m_full[0] = 1; m_rd[0] = alu_rd; m_data[0] = alu_data; m_seq[0] = seq_ctr++;
      end
      if (lsu_valid && rl && lsu_rd != 0) begin
        m_full[1] = 1; m_rd[1] = lsu_rd; m_data[1] = lsu_data; m_seq[1] = seq_ctr++;
      end
      exp_q.push_back(make_exp());
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst) begin
      check("rst_we", WE3, 0);
      check("rst_idle", idle, 1);
      check("rst_hz", {hazard1, hazard2}, 0);
    end else if (exp_q.size() == 0) begin
      check("exp_underflow", 1, 0);
    end else begin
      exp_t e;
      bit h1, h2;
      e  = exp_q.pop_front();
      h1 = (chk_a1 != 0) && ((e.af && e.arr == chk_a1) || (e.lf && e.lrr == chk_a1));
      h2 = (chk_a2 != 0) && ((e.af && e.arr == chk_a2) || (e.lf && e.lrr == chk_a2));
      check("we", WE3, e.we);
      check("ad", AD3, e.ad);
      check("wd", WD3, e.wd);
      check("alu_ready", alu_ready, e.ar);
      check("lsu_ready", lsu_ready, e.lr);
      check("idle", idle, e.idl);
      check("hazard1", hazard1, h1);
      check("hazard2", hazard2, h2);
      if (WE3) rf[AD3] = WD3;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    alu_valid = 0;
    lsu_valid = 0;
  endtask

  task automatic drive_rand(input int n);
    for (int i = 0; i < n; i++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      lsu_valid = ($urandom_range(0, 2) != 0);
      alu_rd    = 5'($urandom_range(0, 7));
      lsu_rd    = 5'($urandom_range(0, 7));
      alu_data  = $urandom;
      lsu_data  = $urandom;
      chk_a1    = 5'($urandom_range(0, 7));
      chk_a2    = 5'($urandom_range(0, 7));
      step();
    end
  endtask

  task automatic drain();
    quiet();
    repeat (6) step();
    check("drain_idle", idle, 1);
  endtask

  initial begin
    int lsu_wins, lsu_rdy;
    foreach (rf[i]) rf[i] = '0;
    rst = 1;
    alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h1234_5678;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    chk_a1 = 0; chk_a2 = 0;

    // Reset held with a valid ALU request pending.
    repeat (3) step();
    check("reset_we", WE3, 0);
    check("reset_idle", idle, 1);
    rst = 0;
    step();
    alu_valid = 0;
    check("first_write", {WE3, AD3, WD3}, {1'b1, 5'd9, 32'h1234_5678});
    drain();

    // Single ALU write with hazard until commit.
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; chk_a1 = 5'd5;
    step();
    alu_valid = 0;
    check("alu5_write", {WE3, AD3, WD3}, {1'b1, 5'd5, 32'hDEAD_BEEF});
    check("alu5_hazard", hazard1, 1);
    step();
    check("alu5_hazard_clear", hazard1, 0);
    drain();

    // Contended stream: LSU wins once per LIMIT+1 cycles.
    alu_valid = 1; alu_rd = 5'd3; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'hB;
    @(posedge clk);
    lsu_wins = 0; lsu_rdy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (WE3 && AD3 == 5'd4) lsu_wins++;
      if (lsu_ready) lsu_rdy++;
    end
    @(posedge clk);
    #1;
`ifdef WB_RR_EN
    check("contended_lsu_wins", lsu_wins, 8);
    check("contended_lsu_ready", lsu_rdy, 8);
`else
    check("contended_lsu_wins", lsu_wins, 4);
    check("contended_lsu_ready", lsu_rdy, 4);
`endif
    drain();

    // Same rd captured together: ALU commits first, LSU value survives.
    chk_a1 = 5'd7;
    alu_valid = 1; alu_rd = 5'd7; alu_data = 32'd1;
    lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 32'd2;
    step();
    quiet();
    check("same_rd_first", {WE3, WD3}, {1'b1, 32'd1});
    check("same_rd_hz1", hazard1, 1);
    step();
    check("same_rd_second", {WE3, WD3}, {1'b1, 32'd2});
    check("same_rd_hz2", hazard1, 1);
    step();
    check("same_rd_hz_clear", hazard1, 0);
    drain();
    check("same_rd_final", rf[7], 32'd2);

    // x0 write from LSU is accepted and dropped.
    chk_a1 = 5'd0;
    lsu_valid = 1; lsu_rd = 5'd0; lsu_data = 32'h55;
    check("x0_ready", lsu_ready, 1);
    step();
    quiet();
    check("x0_no_we", WE3, 0);
    check("x0_idle", idle, 1);
    check("x0_no_hazard", hazard1, 0);
    drain();

    drive_rand(800);
    drain();

    // Asynchronous reset in the middle of traffic.
    drive_rand(40);
    rst = 1;
    #1;
    check("async_rst_we", WE3, 0);
    check("async_rst_idle", idle, 1);
    repeat (2) step();
    rst = 0;
    drive_rand(300);
    drain();
    check("queue_depth", exp_q.size() <= 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
